// File: rtl/boa_extram_pkg.sv
// boa_extram_pkg: shared types and constants for the external-RAM responder.
package boa_extram_pkg;
   typedef enum logic [1:0] {IDLE, WAIT, RESP} extram_state_t;
   typedef enum logic [1:0] {SEL_ZERO, SEL_ONES, SEL_RAM} rdata_sel_t;
   localparam logic [31:0] EXTRAM_OOR_DATA = 32'hffff_ffff;
endpackage

// File: rtl/boa_mem_bus.sv
// boa_mem_bus: simple word-addressed memory bus with byte write enables.
interface boa_mem_bus #(parameter int adrwidth = 19);
   logic                re;
   logic [3:0]          we;
   logic [adrwidth-3:0] addr;
   logic [31:0]         wdata;
   logic                ready;
   logic [31:0]         rdata;
   modport mem (input re, we, addr, wdata, output ready, rdata);
   modport cpu (output re, we, addr, wdata, input ready, rdata);
endinterface

// File: rtl/boa_bram_be.sv
// boa_bram_be: single-port read-first 32-bit RAM with per-byte write mask.
module boa_bram_be #(
   parameter int    depth_log2 = 15,
   parameter string init_file  = ""
) (
   input  logic                  clk,
   input  logic                  en,
   input  logic [3:0]            we,
   input  logic [depth_log2-1:0] addr,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata
);
   logic [31:0] mem [0:(1<<depth_log2)-1];
   initial for (int i = 0; i < (1<<depth_log2); i++) mem[i] = '0;
   always_ff @(posedge clk) begin
      if (en) begin
         rdata <= mem[addr];
         for (int i = 0; i < 4; i++)
            if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
   end
endmodule

// File: rtl/boa_extram_resp.sv
// boa_extram_resp: block-RAM responder for the external-RAM bus with programmable wait states.
module boa_extram_resp
   import boa_extram_pkg::*;
#(
   parameter int    adrwidth    = 19,
   parameter int    depth_log2  = 15,
   parameter int    wait_cycles = 1,
   parameter string init_file   = ""
) (
   input logic     clk,
   input logic     rst,
   boa_mem_bus.mem bus
);
   localparam int aw = adrwidth - 2;
   extram_state_t state, state_n;
   rdata_sel_t    sel;
   logic [3:0]    cnt, we_q, w;
   logic [aw-1:0] addr_q, a;
   logic [31:0]   wdata_q, d, ram_q;
   logic          re_q, r, req, fire, oor;
   assign req = bus.re | (|bus.we);
   // with no wait states the RAM access happens at acceptance, before the latches are loaded
   assign a   = wait_cycles == 0 ? bus.addr  : addr_q;
   assign w   = wait_cycles == 0 ? bus.we    : we_q;
   assign d   = wait_cycles == 0 ? bus.wdata : wdata_q;
   assign r   = wait_cycles == 0 ? bus.re    : re_q;
   assign oor = |(a >> depth_log2);
   always_comb begin
      state_n = state == IDLE ? (req ? (wait_cycles == 0 ? RESP : WAIT) : IDLE) :
                state == WAIT ? (cnt == 4'd1 ? RESP : WAIT) : IDLE;
      fire    = (state == IDLE && req && wait_cycles == 0) || (state == WAIT && cnt == 4'd1);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         we_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         re_q    <= 1'b0;
         sel     <= SEL_ONES;
      end else begin
         state <= state_n;
         if (state == IDLE && req) begin
            addr_q  <= bus.addr;
            we_q    <= bus.we;
            wdata_q <= bus.wdata;
            re_q    <= bus.re;
            cnt     <= 4'(wait_cycles);
         end else if (state == WAIT) begin
            cnt <= cnt - 4'd1;
         end
         if (fire) sel <= !r ? SEL_ZERO : oor ? SEL_ONES : SEL_RAM;
      end
   end
   boa_bram_be #(.depth_log2(depth_log2), .init_file(init_file)) u_ram (
      .clk   (clk),
      .en    (fire & ~rst),
      .we    (oor ? 4'b0 : w),
      .addr  (a[depth_log2-1:0]),
      .wdata (d),
      .rdata (ram_q)
   );
   assign bus.ready = state == RESP || (state == IDLE && !req);
   assign bus.rdata = sel == SEL_RAM ? ram_q : sel == SEL_ONES ? EXTRAM_OOR_DATA : 32'h0;
endmodule

// File: tb/tb_boa_extram_resp.sv
// tb_boa_extram_resp: scoreboard bench over four responders with different wait/depth settings.
module tb_boa_extram_resp;
   typedef struct {
      logic [31:0] d;
      int          lat;
      int          gap;
   } exp_t;
   logic        clk = 1'b0;
   logic        rst   [4];
   logic        re    [4];
   logic [3:0]  we    [4];
   logic [16:0] addr  [4];
   logic [31:0] wdata [4];
   logic        ready [4];
   logic [31:0] rdata [4];
   exp_t        q [4][$];
   int          checks = 0;
   int          fails  = 0;
   always #5 clk = ~clk;
   // instance 0: wc=1, 1: wc=0 depth 10, 2: wc=3, 3: wc=15
   for (genvar g = 0; g < 4; g++) begin : dut
      boa_mem_bus #(19) b ();
      assign b.re      = re[g];
      assign b.we      = we[g];
      assign b.addr    = addr[g];
      assign b.wdata   = wdata[g];
      assign ready[g]  = b.ready;
      assign rdata[g]  = b.rdata;
      boa_extram_resp #(
         .adrwidth    (19),
         .depth_log2  (g == 1 ? 10 : 15),
         .wait_cycles (g == 0 ? 1 : g == 1 ? 0 : g == 2 ? 3 : 15),
         .init_file   ("")
      ) u (
         .clk (clk),
         .rst (rst[g]),
         .bus (b)
      );
   end
   function automatic int wc_of(input int i);
      return i == 0 ? 1 : i == 1 ? 0 : i == 2 ? 3 : 15;
   endfunction
   task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (!ok) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask
   // monitor: a cycle with a request present and ready high is a response
   for (genvar g = 0; g < 4; g++) begin : mon
      int   lat  = 0;
      int   cyc  = 0;
      int   last = 0;
      exp_t e;
      always @(negedge clk) begin
         cyc++;
         if (rst[g]) begin
            lat = 0;
         end else if (re[g] || we[g] != 4'h0) begin
            if (!ready[g]) begin
               lat++;
            end else begin
               if (q[g].size() == 0) begin
                  check(1'b0, $sformatf("unexpected_resp[%0d]", g), rdata[g], 32'h0);
               end else begin
                  e = q[g].pop_front();
                  check(rdata[g] == e.d, $sformatf("rdata[%0d]", g), rdata[g], e.d);
                  check(lat == e.lat, $sformatf("latency[%0d]", g), lat, e.lat);
                  if (e.gap != 0) check(cyc - last == e.gap, $sformatf("spacing[%0d]", g), cyc - last, e.gap);
               end
               last = cyc;
               lat  = 0;
            end
         end else begin
            check(ready[g] == 1'b1, $sformatf("idle_ready[%0d]", g), {31'h0, ready[g]}, 32'h1);
         end
      end
   end
   task automatic acc(input int i, input logic r, input logic [3:0] w, input logic [16:0] a,
                      input logic [31:0] d, input logic [31:0] exp, input int n);
      int got = 0;
      for (int k = 0; k < n; k++) q[i].push_back('{exp, wc_of(i) + 1, k == 0 ? 0 : wc_of(i) + 2});
      re[i] = r; we[i] = w; addr[i] = a; wdata[i] = d;
      for (int c = 0; c < 100 && got < n; c++) begin
         @(negedge clk);
         if (ready[i]) got++;
      end
      check(got == n, $sformatf("timeout[%0d]", i), got, n);
      @(posedge clk); #1;
      re[i] = 1'b0; we[i] = 4'h0;
   endtask
   initial begin
      for (int i = 0; i < 4; i++) begin
         rst[i] = 1'b1; re[i] = 1'b0; we[i] = 4'h0; addr[i] = '0; wdata[i] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) rst[i] = 1'b0;
      @(negedge clk);
      check(rdata[0] == 32'hffff_ffff, "reset_rdata", rdata[0], 32'hffff_ffff);
      check(ready[0] == 1'b1, "reset_ready", {31'h0, ready[0]}, 32'h1);
      @(posedge clk); #1;
      acc(0, 1'b0, 4'hf, 17'h10, 32'hdead_beef, 32'h0, 1);
      acc(0, 1'b1, 4'h0, 17'h10, 32'h0, 32'hdead_beef, 1);
      acc(0, 1'b0, 4'hf, 17'h11, 32'h1122_3344, 32'h0, 1);
      acc(0, 1'b0, 4'b0101, 17'h11, 32'haabb_ccdd, 32'h0, 1);
      acc(0, 1'b1, 4'h0, 17'h11, 32'h0, 32'h11bb_33dd, 1);
      acc(0, 1'b0, 4'hf, 17'h12, 32'h0000_0001, 32'h0, 1);
      acc(0, 1'b1, 4'hf, 17'h12, 32'h0000_0002, 32'h0000_0001, 1);
      acc(0, 1'b1, 4'h0, 17'h12, 32'h0, 32'h0000_0002, 1);
      acc(0, 1'b1, 4'h0, 17'h10, 32'h0, 32'hdead_beef, 2);
      acc(1, 1'b0, 4'hf, 17'h5, 32'h1234_5678, 32'h0, 3);
      acc(2, 1'b0, 4'hf, 17'h5, 32'h1234_5678, 32'h0, 3);
      acc(3, 1'b0, 4'hf, 17'h5, 32'h1234_5678, 32'h0, 2);
      acc(1, 1'b1, 4'h0, 17'h5, 32'h0, 32'h1234_5678, 1);
      acc(1, 1'b0, 4'hf, 17'h0, 32'ha5a5_a5a5, 32'h0, 1);
      acc(1, 1'b0, 4'hf, 17'h400, 32'h5555_5555, 32'h0, 1);
      acc(1, 1'b1, 4'h0, 17'h0, 32'h0, 32'ha5a5_a5a5, 1);
      acc(1, 1'b1, 4'h0, 17'h400, 32'h0, 32'hffff_ffff, 1);
      acc(1, 1'b1, 4'hf, 17'h400, 32'h1, 32'hffff_ffff, 1);
      acc(1, 1'b1, 4'h0, 17'h0, 32'h0, 32'ha5a5_a5a5, 1);
      acc(2, 1'b0, 4'hf, 17'h20, 32'hcafe_f00d, 32'h0, 1);
      we[2] = 4'hf; addr[2] = 17'h20; wdata[2] = 32'h1234_5678;
      @(posedge clk); #1;
      rst[2] = 1'b1; we[2] = 4'h0;
      @(posedge clk); #1;
      rst[2] = 1'b0;
      @(negedge clk);
      check(ready[2] == 1'b1, "post_reset_ready", {31'h0, ready[2]}, 32'h1);
      @(posedge clk); #1;
      acc(2, 1'b1, 4'h0, 17'h20, 32'h0, 32'hcafe_f00d, 1);
      repeat (3) @(posedge clk);
      for (int i = 0; i < 4; i++) check(q[i].size() == 0, $sformatf("pending[%0d]", i), q[i].size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
